// File: rtl/layer_sequencer.sv
// Forward-pass controller for a stack of cached dilated conv1d layers.
// One sample tick drives: shift-buffer clock, per-layer conv start/wait/cache clock, output latch.
module layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sample_clk,
    input  logic [$clog2(NUM_LAYERS+1)-1:0]  active_layers,
    input  logic [NUM_LAYERS-1:0]            conv_out_v,
    input  logic                             status_clr,
    output logic                             lsb_clk,
    output logic [NUM_LAYERS-1:0]            conv_rst,
    output logic [NUM_LAYERS-2:0]            ac_clk,
    output logic                             out_latch,
    output logic                             busy,
    output logic                             overrun,
    output logic                             timeout_err,
    output logic [CNT_W-1:0]                 last_cycles
);

    localparam int LW     = $clog2(NUM_LAYERS + 1);
    localparam int LIW    = $clog2(NUM_LAYERS);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLK_LSB,
        S_RST_CONV,
        S_CONV_RUN,
        S_CLK_CACHE,
        S_OUTPUT
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic sample_p0, sample_p1, sample_p2;
    logic tick;

    state_t            state_q, state_d;
    logic [LIW-1:0]    layer_q, layer_d;
    logic [LIW-1:0]    last_layer_q, last_layer_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LW-1:0]     n_sel;
    logic              timeout_hit;
    logic              run_done;

    logic                  lsb_clk_d;
    logic [NUM_LAYERS-1:0] conv_rst_d;
    logic [NUM_LAYERS-2:0] ac_clk_d;
    logic                  out_latch_d;
    logic                  busy_d;

    // Stage p0/p1: two-flop synchroniser; p2 holds the previous synchronised value for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_p0 <= 1'b0;
            sample_p1 <= 1'b0;
            sample_p2 <= 1'b0;
        end else begin
            sample_p0 <= sample_clk;
            sample_p1 <= sample_p0;
            sample_p2 <= sample_p1;
        end
    end

    assign tick = sample_p1 & ~sample_p2;

    always_comb begin
        state_d      = state_q;
        layer_d      = layer_q;
        last_layer_d = last_layer_q;
        wait_d       = wait_q;
        cnt_d        = '0;
        timeout_hit  = 1'b0;
        run_done     = 1'b0;

        n_sel = active_layers;
        if (active_layers == '0 || active_layers > LW'(NUM_LAYERS))
            n_sel = LW'(NUM_LAYERS);

        if (state_q != S_IDLE)
            cnt_d = sat_inc(cnt_q);

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d      = S_CLK_LSB;
                    layer_d      = '0;
                    last_layer_d = LIW'(n_sel - LW'(1));
                end
            end
            S_CLK_LSB: begin
                state_d = S_RST_CONV;
            end
            S_RST_CONV: begin
                wait_d  = '0;
                state_d = S_CONV_RUN;
            end
            S_CONV_RUN: begin
                if (conv_out_v[layer_q]) begin
                    state_d = (layer_q == last_layer_q) ? S_OUTPUT : S_CLK_CACHE;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_CLK_CACHE: begin
                layer_d = layer_q + LIW'(1);
                state_d = S_RST_CONV;
            end
            S_OUTPUT: begin
                run_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pulses are decoded from the next state and registered, so each output is a clean flop
    always_comb begin
        lsb_clk_d   = (state_d == S_CLK_LSB);
        out_latch_d = (state_d == S_OUTPUT);
        busy_d      = (state_d != S_IDLE);
        conv_rst_d  = '0;
        ac_clk_d    = '0;
        for (int k = 0; k < NUM_LAYERS; k++)
            conv_rst_d[k] = (state_d == S_RST_CONV) && (layer_d == LIW'(k));
        for (int k = 0; k < NUM_LAYERS - 1; k++)
            ac_clk_d[k] = (state_d == S_CLK_CACHE) && (layer_d == LIW'(k));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            layer_q      <= '0;
            last_layer_q <= '0;
            wait_q       <= '0;
            cnt_q        <= '0;
            last_cycles  <= '0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
            lsb_clk      <= 1'b0;
            conv_rst     <= '0;
            ac_clk       <= '0;
            out_latch    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            last_layer_q <= last_layer_d;
            wait_q       <= wait_d;
            cnt_q        <= cnt_d;
            lsb_clk      <= lsb_clk_d;
            conv_rst     <= conv_rst_d;
            ac_clk       <= ac_clk_d;
            out_latch    <= out_latch_d;
            busy         <= busy_d;

            if (run_done)
                last_cycles <= sat_inc(cnt_q);

            // Sticky flags: a set in the same cycle as a clear takes priority
            if (tick && (state_q != S_IDLE))
                overrun <= 1'b1;
            else if (status_clr)
                overrun <= 1'b0;

            if (timeout_hit)
                timeout_err <= 1'b1;
            else if (status_clr)
                timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: pulse ordering, run length, clamping, overrun, timeout, reset abort.
module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_clk;
    logic [1:0]  active_layers;
    logic [2:0]  conv_out_v = '0;
    logic        status_clr;
    logic        lsb_clk;
    logic [2:0]  conv_rst;
    logic [1:0]  ac_clk;
    logic        out_latch;
    logic        busy;
    logic        overrun;
    logic        timeout_err;
    logic [15:0] last_cycles;

    int total = 0;
    int bad   = 0;

    bit [2:0] stall = '0;
    int       ccnt[3];
    bit       armed[3];

    layer_sequencer #(
        .NUM_LAYERS(3),
        .TIMEOUT   (8),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_clk   (sample_clk),
        .active_layers(active_layers),
        .conv_out_v   (conv_out_v),
        .status_clr   (status_clr),
        .lsb_clk      (lsb_clk),
        .conv_rst     (conv_rst),
        .ac_clk       (ac_clk),
        .out_latch    (out_latch),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err),
        .last_cycles  (last_cycles)
    );

    always #5 clk = ~clk;

    // Conv stand-in: out_v rises in the 3rd cycle after its start pulse unless stalled
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (conv_rst[k]) begin
                ccnt[k]       = 0;
                armed[k]      = 1'b1;
                conv_out_v[k] = 1'b0;
            end else if (armed[k]) begin
                ccnt[k]++;
                if (ccnt[k] >= 3 && !stall[k]) begin
                    conv_out_v[k] = 1'b1;
                    armed[k]      = 1'b0;
                end
            end
        end
    end

    // Raises sample_clk once (and optionally again at cycle 'retick'), records pulses until busy falls
    task automatic run_tick(input int retick, output string seq, output int busy_n,
                            output int lsb_at, output bit done);
        bit seen_busy;
        seq       = "";
        busy_n    = 0;
        lsb_at    = -1;
        done      = 1'b0;
        seen_busy = 1'b0;
        @(negedge clk);
        sample_clk = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 2) sample_clk = 1'b0;
            if (retick > 0 && c == retick) sample_clk = 1'b1;
            if (retick > 0 && c == retick + 3) sample_clk = 1'b0;
            if (lsb_clk) begin
                seq = {seq, "L "};
                if (lsb_at < 0) lsb_at = c;
            end
            for (int k = 0; k < 3; k++)
                if (conv_rst[k]) seq = {seq, $sformatf("R%0d ", k)};
            for (int k = 0; k < 2; k++)
                if (ac_clk[k]) seq = {seq, $sformatf("A%0d ", k)};
            if (out_latch) seq = {seq, "O "};
            if (busy) begin
                busy_n++;
                seen_busy = 1'b1;
            end else if (seen_busy) begin
                done = 1'b1;
                break;
            end
        end
        sample_clk = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({lsb_clk, conv_rst, ac_clk, out_latch, busy} !== 8'b0) begin
            bad++;
            $display("FAIL reset_pulses: got %b expected 00000000", {lsb_clk, conv_rst, ac_clk, out_latch, busy});
        end
        total++;
        if ({overrun, timeout_err} !== 2'b00) begin
            bad++;
            $display("FAIL reset_flags: got %b expected 00", {overrun, timeout_err});
        end
        total++;
        if (last_cycles !== 16'd0) begin
            bad++;
            $display("FAIL reset_last_cycles: got %0d expected 0", last_cycles);
        end
        rst = 1'b0;
    endtask

    task automatic test_three_layers();
        string seq; int bn, la; bit done;
        active_layers = 2'd3;
        run_tick(0, seq, bn, la, done);
        total++;
        if (!done) begin bad++; $display("FAIL three_done: got 0 expected 1"); end
        total++;
        if (seq != "L R0 A0 R1 A1 R2 O ") begin
            bad++;
            $display("FAIL three_seq: got '%s' expected 'L R0 A0 R1 A1 R2 O '", seq);
        end
        total++;
        if (la !== 3) begin bad++; $display("FAIL three_lsb_latency: got %0d expected 3", la); end
        total++;
        if (bn !== 16) begin bad++; $display("FAIL three_busy: got %0d expected 16", bn); end
        total++;
        if (last_cycles !== 16'd16) begin
            bad++;
            $display("FAIL three_last_cycles: got %0d expected 16", last_cycles);
        end
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL three_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_two_layers();
        string seq; int bn, la; bit done;
        active_layers = 2'd2;
        run_tick(0, seq, bn, la, done);
        total++;
        if (!done) begin bad++; $display("FAIL two_done: got 0 expected 1"); end
        total++;
        if (seq != "L R0 A0 R1 O ") begin
            bad++;
            $display("FAIL two_seq: got '%s' expected 'L R0 A0 R1 O '", seq);
        end
        total++;
        if (bn !== 11) begin bad++; $display("FAIL two_busy: got %0d expected 11", bn); end
        total++;
        if (last_cycles !== 16'd11) begin
            bad++;
            $display("FAIL two_last_cycles: got %0d expected 11", last_cycles);
        end
    endtask

    task automatic test_clamp_zero();
        string seq; int bn, la; bit done;
        active_layers = 2'd0;
        run_tick(0, seq, bn, la, done);
        total++;
        if (seq != "L R0 A0 R1 A1 R2 O ") begin
            bad++;
            $display("FAIL zero_seq: got '%s' expected 'L R0 A0 R1 A1 R2 O '", seq);
        end
        total++;
        if (last_cycles !== 16'd16) begin
            bad++;
            $display("FAIL zero_last_cycles: got %0d expected 16", last_cycles);
        end
    endtask

    task automatic test_overrun();
        string seq; int bn, la; bit done; int idle_busy;
        active_layers = 2'd3;
        run_tick(5, seq, bn, la, done);
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        total++;
        if (seq != "L R0 A0 R1 A1 R2 O ") begin
            bad++;
            $display("FAIL ovr_seq: got '%s' expected 'L R0 A0 R1 A1 R2 O '", seq);
        end
        total++;
        if (last_cycles !== 16'd16) begin
            bad++;
            $display("FAIL ovr_last_cycles: got %0d expected 16", last_cycles);
        end
        idle_busy = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || lsb_clk) idle_busy++;
        end
        total++;
        if (idle_busy !== 0) begin
            bad++;
            $display("FAIL ovr_no_restart: got %0d active cycles expected 0", idle_busy);
        end
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        run_tick(0, seq, bn, la, done);
        total++;
        if (seq != "L R0 A0 R1 A1 R2 O " || overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_clean_run: got '%s' overrun=%b expected 'L R0 A0 R1 A1 R2 O ' overrun=0", seq, overrun);
        end
    endtask

    task automatic test_timeout();
        string seq; int bn, la; bit done;
        active_layers = 2'd3;
        stall[1] = 1'b1;
        run_tick(0, seq, bn, la, done);
        stall[1] = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL to_done: got 0 expected 1"); end
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_flag: got %b expected 1", timeout_err); end
        total++;
        if (seq != "L R0 A0 R1 ") begin
            bad++;
            $display("FAIL to_seq: got '%s' expected 'L R0 A0 R1 '", seq);
        end
        total++;
        if (bn !== 15) begin bad++; $display("FAIL to_busy: got %0d expected 15", bn); end
        total++;
        if (last_cycles !== 16'd16) begin
            bad++;
            $display("FAIL to_last_kept: got %0d expected 16", last_cycles);
        end
        active_layers = 2'd2;
        run_tick(0, seq, bn, la, done);
        total++;
        if (seq != "L R0 A0 R1 O " || last_cycles !== 16'd11) begin
            bad++;
            $display("FAIL to_next_run: got '%s' last=%0d expected 'L R0 A0 R1 O ' last=11", seq, last_cycles);
        end
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear: got %b expected 0", timeout_err); end
    endtask

    task automatic test_rst_midrun();
        bit seen_r1; int active;
        string seq; int bn, la; bit done;
        active_layers = 2'd3;
        seen_r1 = 1'b0;
        @(negedge clk);
        sample_clk = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 2) sample_clk = 1'b0;
            if (c == 5) sample_clk = 1'b1;
            if (c == 8) sample_clk = 1'b0;
            if (conv_rst[1]) begin
                seen_r1 = 1'b1;
                break;
            end
        end
        total++;
        if (!seen_r1) begin bad++; $display("FAIL rst_reach_layer1: got 0 expected 1"); end
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL rst_pre_overrun: got %b expected 1", overrun); end
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({lsb_clk, conv_rst, ac_clk, out_latch, busy, overrun, timeout_err} !== 10'b0) begin
            bad++;
            $display("FAIL rst_abort_outputs: got %b expected 0000000000",
                     {lsb_clk, conv_rst, ac_clk, out_latch, busy, overrun, timeout_err});
        end
        total++;
        if (last_cycles !== 16'd0) begin
            bad++;
            $display("FAIL rst_abort_last: got %0d expected 0", last_cycles);
        end
        rst = 1'b0;
        active = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || lsb_clk || conv_rst != 3'b0 || ac_clk != 2'b0 || out_latch) active++;
        end
        total++;
        if (active !== 0) begin
            bad++;
            $display("FAIL rst_quiet: got %0d active cycles expected 0", active);
        end
        run_tick(0, seq, bn, la, done);
        total++;
        if (seq != "L R0 A0 R1 A1 R2 O " || last_cycles !== 16'd16) begin
            bad++;
            $display("FAIL rst_next_run: got '%s' last=%0d expected 'L R0 A0 R1 A1 R2 O ' last=16", seq, last_cycles);
        end
    endtask

    initial begin
        rst           = 1'b1;
        sample_clk    = 1'b0;
        active_layers = 2'd3;
        status_clr    = 1'b0;
        test_reset();
        test_three_layers();
        test_two_layers();
        test_clamp_zero();
        test_overrun();
        test_timeout();
        test_rst_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
